// File: rtl/opto_input_conditioner.sv
// opto_input_conditioner: synchronizes and deglitches one opto-coupled input,
// applies a re-trigger hold-off and keeps event/rejection/period statistics.
`default_nettype none

module opto_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 16,
    parameter int HOLDOFF     = 10_000,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             opto_in,
    output logic             level_out,
    output logic             pulse_out,
    output logic [CNT_W-1:0] event_count,
    output logic [15:0]      rejected_count,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
);

    localparam int              HCNT_W    = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [15:0]     FILT_LAST = 16'(FILTER_LEN - 1);
    localparam logic [HCNT_W-1:0] HOLD_LOAD = HCNT_W'(HOLDOFF);

    typedef enum logic [1:0] {
        ST_LOW       = 2'b00,
        ST_QUAL_HIGH = 2'b01,
        ST_HIGH      = 2'b10,
        ST_QUAL_LOW  = 2'b11
    } filt_state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    filt_state_t            state_q;
    logic [15:0]            fcnt_q;
    logic [HCNT_W-1:0]      hcnt_q, hcnt_d;
    logic [CNT_W-1:0]       pcnt_q, pcnt_d;
    logic [CNT_W-1:0]       event_count_q, event_count_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [15:0]            rejected_q, rejected_d;
    logic                   pulse_q, pulse_d;
    logic                   pvalid_q, pvalid_d;
    logic                   have_prev_q, have_prev_d;

    logic             s;
    logic             level;
    logic             differs;
    logic             rise;
    logic             hold_clear;
    logic             accept;
    logic             reject;
    logic [CNT_W-1:0] pcnt_inc;

    always_ff @(posedge clock) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], opto_in};
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign level   = (state_q == ST_HIGH) || (state_q == ST_QUAL_LOW);
    assign differs = (s != level);
    assign rise    = differs && !level && (fcnt_q == FILT_LAST);

    // Filter FSM: the qualifying states mark an in-progress level change.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_LOW;
            fcnt_q  <= '0;
        end else if (!differs) begin
            fcnt_q  <= '0;
            state_q <= level ? ST_HIGH : ST_LOW;
        end else if (fcnt_q == FILT_LAST) begin
            fcnt_q  <= '0;
            state_q <= level ? ST_LOW : ST_HIGH;
        end else begin
            fcnt_q  <= 16'(fcnt_q + 16'd1);
            state_q <= level ? ST_QUAL_LOW : ST_QUAL_HIGH;
        end
    end

    // An edge arriving as the hold-off counter expires (1 -> 0) is accepted,
    // so pulses exactly HOLDOFF cycles apart both pass.
    assign hold_clear = (hcnt_q <= HCNT_W'(1));
    assign accept     = rise && enable && hold_clear;
    assign reject     = rise && enable && !hold_clear;
    assign pcnt_inc   = (&pcnt_q) ? pcnt_q : CNT_W'(pcnt_q + CNT_W'(1));

    always_comb begin
        hcnt_d        = (hcnt_q != '0) ? HCNT_W'(hcnt_q - HCNT_W'(1)) : hcnt_q;
        pcnt_d        = pcnt_inc;
        event_count_d = event_count_q;
        period_d      = period_q;
        rejected_d    = rejected_q;
        pulse_d       = 1'b0;
        pvalid_d      = 1'b0;
        have_prev_d   = have_prev_q;
        if (accept) begin
            hcnt_d        = HOLD_LOAD;
            pcnt_d        = '0;
            event_count_d = CNT_W'(event_count_q + CNT_W'(1));
            pulse_d       = 1'b1;
            pvalid_d      = have_prev_q;
            have_prev_d   = 1'b1;
            if (have_prev_q) period_d = pcnt_inc;
        end
        if (reject && (rejected_q != 16'hFFFF)) rejected_d = 16'(rejected_q + 16'd1);
        if (!enable) have_prev_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hcnt_q        <= '0;
            pcnt_q        <= '0;
            event_count_q <= '0;
            period_q      <= '0;
            rejected_q    <= '0;
            pulse_q       <= 1'b0;
            pvalid_q      <= 1'b0;
            have_prev_q   <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            pcnt_q        <= pcnt_d;
            event_count_q <= event_count_d;
            period_q      <= period_d;
            rejected_q    <= rejected_d;
            pulse_q       <= pulse_d;
            pvalid_q      <= pvalid_d;
            have_prev_q   <= have_prev_d;
        end
    end

    assign level_out      = level;
    assign pulse_out      = pulse_q;
    assign period_valid   = pvalid_q;
    assign event_count    = event_count_q;
    assign period         = period_q;
    assign rejected_count = rejected_q;

endmodule

`default_nettype wire
